gpi_debounce: RTL and testbench

Synchronises and debounces the board's switch and push-button inputs before they reach the demo system's general-purpose input port. Each bit passes through a multi-flop synchroniser and then a per-bit stability counter. A bit's output level changes only after its synchronised input has held a new value for a programmable number of consecutive `clk_sys_i` cycles. Single-cycle rise and fall strobes are also produced, so software or peripherals can detect presses without polling for edges.

---
 rtl/gpi_debounce_bit.sv | 52 +++++
 rtl/gpi_debounce.sv | 32 +++
 tb/tb_gpi_debounce.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/gpi_debounce_bit.sv
// One input bit: multi-flop synchroniser, stability counter, debounced level
// register and single-cycle rise/fall strobes.
module gpi_debounce_bit #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 500000,
  parameter logic        ResetValue     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  (* ASYNC_REG = "TRUE" *) logic [SyncStages-1:0] sync_q;
  logic [CntW-1:0] cnt_q;
  logic            sync;

  assign sync = sync_q[SyncStages-1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SyncStages{ResetValue}};
      cnt_q  <= '0;
      level  <= ResetValue;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], raw};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sync == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        // Held long enough: accept the new level and flag the edge once.
        cnt_q <= '0;
        level <= sync;
        rise  <= sync;
        fall  <= ~sync;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpi_debounce.sv
// Synchronises and debounces the board switch/button inputs; each bit is an
// independent gpi_debounce_bit instance.
module gpi_debounce #(
  parameter int unsigned     Width          = 20,
  parameter int unsigned     SyncStages     = 2,
  parameter int unsigned     DebounceCycles = 500000,
  parameter logic [Width-1:0] ResetValue    = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    gpi_debounce_bit #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles),
      .ResetValue    (ResetValue[i])
    ) u_bit (
      .clk  (clk_sys_i),
      .rst  (rst_sys_i),
      .raw  (gp_raw_i[i]),
      .level(gp_o[i]),
      .rise (rise_o[i]),
      .fall (fall_o[i])
    );
  end

endmodule

// File: tb/tb_gpi_debounce.sv
// Scoreboard bench for gpi_debounce: three instances (DebounceCycles 8, 8 with
// non-zero reset value, and 1), hand-computed per-cycle expectations.
module tb_gpi_debounce;

  localparam int DUT_A = 0;  // DebounceCycles=8, ResetValue=0
  localparam int DUT_B = 1;  // DebounceCycles=8, ResetValue=1010
  localparam int DUT_C = 2;  // DebounceCycles=1

  typedef struct {
    int         sel;
    string      tag;
    logic [3:0] gp;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [3:0] raw_a = 4'b0000, raw_b = 4'b1010, raw_c = 4'b0000;
  logic [3:0] gp_a, rise_a, fall_a;
  logic [3:0] gp_b, rise_b, fall_b;
  logic [3:0] gp_c, rise_c, fall_c;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gpi_debounce #(.Width(4), .SyncStages(2), .DebounceCycles(8), .ResetValue(4'b0000)) u_dut_a (
    .clk_sys_i(clk), .rst_sys_i(rst_a), .gp_raw_i(raw_a),
    .gp_o(gp_a), .rise_o(rise_a), .fall_o(fall_a)
  );

  gpi_debounce #(.Width(4), .SyncStages(2), .DebounceCycles(8), .ResetValue(4'b1010)) u_dut_b (
    .clk_sys_i(clk), .rst_sys_i(rst_b), .gp_raw_i(raw_b),
    .gp_o(gp_b), .rise_o(rise_b), .fall_o(fall_b)
  );

  gpi_debounce #(.Width(4), .SyncStages(2), .DebounceCycles(1), .ResetValue(4'b0000)) u_dut_c (
    .clk_sys_i(clk), .rst_sys_i(rst_c), .gp_raw_i(raw_c),
    .gp_o(gp_c), .rise_o(rise_c), .fall_o(fall_c)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, want);
    end
  endtask

  // One cycle: after the edge, apply rst/raw to the selected DUT and queue the
  // outputs that DUT must show following that same edge.
  task automatic drive(input int sel, input logic rst, input logic [3:0] raw,
                       input logic [3:0] gp, input logic [3:0] rise,
                       input logic [3:0] fall, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    case (sel)
      DUT_A:   begin rst_a = rst; raw_a = raw; end
      DUT_B:   begin rst_b = rst; raw_b = raw; end
      default: begin rst_c = rst; raw_c = raw; end
    endcase
    e.sel  = sel;
    e.tag  = tag;
    e.gp   = gp;
    e.rise = rise;
    e.fall = fall;
    exp_q.push_back(e);
  endtask

  task automatic run(input int sel, input int n, input logic [3:0] raw,
                     input logic [3:0] gp, input string tag);
    for (int i = 0; i < n; i++) drive(sel, 1'b0, raw, gp, 4'b0000, 4'b0000, tag);
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] g, r, f;
      e = exp_q.pop_front();
      case (e.sel)
        DUT_A:   begin g = gp_a; r = rise_a; f = fall_a; end
        DUT_B:   begin g = gp_b; r = rise_b; f = fall_b; end
        default: begin g = gp_c; r = rise_c; f = fall_c; end
      endcase
      check({e.tag, " gp"},   g, e.gp);
      check({e.tag, " rise"}, r, e.rise);
      check({e.tag, " fall"}, f, e.fall);
    end
  end

  initial begin
    repeat (2) @(posedge clk);

    // 1: reset state and quiet input
    drive(DUT_A, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "t1 in_rst");
    drive(DUT_A, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "t1 release");
    run(DUT_A, 50, 4'b0000, 4'b0000, "t1 idle");

    // 1b: non-zero reset value matching the pins gives no strobes
    run(DUT_B, 12, 4'b1010, 4'b1010, "t1b hold");
    run(DUT_B, 10, 4'b1000, 4'b1010, "t1b wait");
    drive(DUT_B, 1'b0, 4'b1000, 4'b1000, 4'b0000, 4'b0010, "t1b fall");
    run(DUT_B, 3, 4'b1000, 4'b1000, "t1b after");

    // 2: clean step on bit 0, both directions, change at edge k+10
    run(DUT_A, 10, 4'b0001, 4'b0000, "t2 wait_rise");
    drive(DUT_A, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "t2 rise");
    run(DUT_A, 5, 4'b0001, 4'b0001, "t2 high");
    run(DUT_A, 10, 4'b0000, 4'b0001, "t2 wait_fall");
    drive(DUT_A, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "t2 fall");
    run(DUT_A, 5, 4'b0000, 4'b0000, "t2 low");

    // 3: bounce on bit 1 (7 high, 1 low, 7 high) is rejected
    run(DUT_A, 7, 4'b0010, 4'b0000, "t3 bounce_a");
    run(DUT_A, 1, 4'b0000, 4'b0000, "t3 gap");
    run(DUT_A, 7, 4'b0010, 4'b0000, "t3 bounce_b");
    run(DUT_A, 12, 4'b0000, 4'b0000, "t3 flush");
    // exactly 8 cycles high is accepted, then the return low is accepted too
    run(DUT_A, 8, 4'b0010, 4'b0000, "t3 high8");
    run(DUT_A, 2, 4'b0000, 4'b0000, "t3 wait_rise");
    drive(DUT_A, 1'b0, 4'b0000, 4'b0010, 4'b0010, 4'b0000, "t3 rise");
    run(DUT_A, 7, 4'b0000, 4'b0010, "t3 wait_fall");
    drive(DUT_A, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, "t3 fall");
    run(DUT_A, 4, 4'b0000, 4'b0000, "t3 low");

    // 4: bits 2 and 3 step together
    run(DUT_A, 10, 4'b1100, 4'b0000, "t4 wait_rise");
    drive(DUT_A, 1'b0, 4'b1100, 4'b1100, 4'b1100, 4'b0000, "t4 rise");
    run(DUT_A, 3, 4'b1100, 4'b1100, "t4 high");
    run(DUT_A, 10, 4'b0000, 4'b1100, "t4 wait_fall");
    drive(DUT_A, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1100, "t4 fall");
    run(DUT_A, 3, 4'b0000, 4'b0000, "t4 low");

    // 5: reset while bit 0's counter sits at 5
    run(DUT_A, 7, 4'b0001, 4'b0000, "t5 count");
    drive(DUT_A, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "t5 assert");
    drive(DUT_A, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "t5 reset_edge");
    run(DUT_A, 9, 4'b0001, 4'b0000, "t5 restart");
    drive(DUT_A, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "t5 rise");
    run(DUT_A, 3, 4'b0001, 4'b0001, "t5 high");

    // 6: DebounceCycles=1, 1-cycle pulse on bit 0 and 3-cycle pulse on bit 2
    run(DUT_C, 4, 4'b0000, 4'b0000, "t6 idle");
    drive(DUT_C, 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, "t6 k0");
    drive(DUT_C, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, "t6 k1");
    drive(DUT_C, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, "t6 k2");
    drive(DUT_C, 1'b0, 4'b0000, 4'b0101, 4'b0101, 4'b0000, "t6 k3");
    drive(DUT_C, 1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0001, "t6 k4");
    drive(DUT_C, 1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, "t6 k5");
    drive(DUT_C, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, "t6 k6");
    run(DUT_C, 2, 4'b0000, 4'b0000, "t6 low");

    repeat (2) @(negedge clk);
    check("scoreboard drained", 4'(exp_q.size()), 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
